// File: rtl/jk_cmd_sequencer_pkg.sv
// Shared encodings for the JK command sequencer: {j,k} command codes, FSM states
// and the reference next-state function of a JK flip-flop.
package jk_cmd_sequencer_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        logic q_nxt;
        q_nxt = q;
        case (jk)
            JK_HOLD:   q_nxt = q;
            JK_RESET:  q_nxt = 1'b0;
            JK_SET:    q_nxt = 1'b1;
            JK_TOGGLE: q_nxt = ~q;
            default:   q_nxt = q;
        endcase
        return q_nxt;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with a show-ahead head entry; DEPTH must be a power of
// two so the pointers wrap on their own.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // NOTE: the storage array has no reset; pointers and count alone define
    // which entries are valid, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers {j,k,hold} commands, drives them onto a JK flop for hold+1 cycles each,
// and checks the flop output against a golden JK model with a sticky mismatch flag.
module jk_cmd_sequencer
    import jk_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_jk,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              j,
    output logic              k,
    input  logic              q_obs,
    output logic              q_exp,
    output logic              exp_valid,
    output logic              mismatch,
    output logic              busy
);

    localparam int CMD_W = HOLD_W + 2;

    state_t            state;
    logic [HOLD_W-1:0] cnt;
    logic              ready_en;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CMD_W-1:0]  head;
    logic [1:0]        head_jk;
    logic [HOLD_W-1:0] head_hold;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({cmd_jk, cmd_hold}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_jk   = head[HOLD_W +: 2];
    assign head_hold = head[HOLD_W-1:0];

    // ready_en holds cmd_ready low until the first edge after reset release.
    assign cmd_ready = ready_en & ~fifo_full;
    assign push      = cmd_valid & cmd_ready;
    assign pop       = ~fifo_empty & ((state == ST_IDLE) | (cnt == '0));
    assign busy      = (state == ST_RUN) | ~fifo_empty;

    // NOTE: all state here is updated with non-blocking assignments so every
    // right-hand side (j, k, q_exp, cnt) reads the value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            j         <= 1'b0;
            k         <= 1'b0;
            q_exp     <= 1'b0;
            exp_valid <= 1'b0;
            mismatch  <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;

            q_exp <= jk_next(q_exp, {j, k});
            if (({j, k} == JK_RESET) || ({j, k} == JK_SET)) begin
                exp_valid <= 1'b1;
            end
            if (exp_valid && (q_obs != q_exp)) begin
                mismatch <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        {j, k} <= head_jk;
                        cnt    <= head_hold;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (pop) begin
                        {j, k} <= head_jk;
                        cnt    <= head_hold;
                    end else begin
                        {j, k} <= JK_HOLD;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    {j, k} <= JK_HOLD;
                    cnt    <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with a behavioural JK flop on q_obs that can
// be overridden to inject a wrong observed value.
module tb_jk_cmd_sequencer;

    localparam int DEPTH  = 4;
    localparam int HOLD_W = 4;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_jk;
    logic [HOLD_W-1:0] cmd_hold;
    logic              j;
    logic              k;
    logic              q_obs;
    logic              q_exp;
    logic              exp_valid;
    logic              mismatch;
    logic              busy;

    logic q_ff;
    logic force_en;
    logic force_val;

    int n_checks;
    int n_fail;

    jk_cmd_sequencer #(
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_jk    (cmd_jk),
        .cmd_hold  (cmd_hold),
        .j         (j),
        .k         (k),
        .q_obs     (q_obs),
        .q_exp     (q_exp),
        .exp_valid (exp_valid),
        .mismatch  (mismatch),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the jkff flop driven by the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_ff <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end

    assign q_obs = force_en ? force_val : q_ff;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] jk, input logic [HOLD_W-1:0] hold);
        cmd_valid = v;
        cmd_jk    = jk;
        cmd_hold  = hold;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        force_en  = 1'b0;
        force_val = 1'b0;
        drive(1'b0, 2'b00, '0);

        // Reset state
        tick();
        tick();
        check("rst_j", j, 1'b0);
        check("rst_k", k, 1'b0);
        check("rst_q_exp", q_exp, 1'b0);
        check("rst_exp_valid", exp_valid, 1'b0);
        check("rst_mismatch", mismatch, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", cmd_ready, 1'b0);
        tick();
        check("ready_after_edge", cmd_ready, 1'b1);

        // Single RESET command, hold=0
        drive(1'b1, 2'b01, 4'd0);
        tick();
        drive(1'b0, 2'b00, 4'd0);
        check("t1_busy_queued", busy, 1'b1);
        check("t1_jk_queued", {j, k}, 2'b00);
        tick();
        check("t1_jk_applied", {j, k}, 2'b01);
        check("t1_exp_valid_pre", exp_valid, 1'b0);
        tick();
        check("t1_jk_idle", {j, k}, 2'b00);
        check("t1_exp_valid", exp_valid, 1'b1);
        check("t1_q_exp", q_exp, 1'b0);
        check("t1_mismatch", mismatch, 1'b0);
        check("t1_busy_done", busy, 1'b0);

        // Back-to-back 01,10,00,11
        drive(1'b1, 2'b01, 4'd0);
        tick();
        drive(1'b1, 2'b10, 4'd0);
        tick();
        check("t2_jk0", {j, k}, 2'b01);
        drive(1'b1, 2'b00, 4'd0);
        tick();
        check("t2_jk1", {j, k}, 2'b10);
        check("t2_q0", q_exp, 1'b0);
        drive(1'b1, 2'b11, 4'd0);
        tick();
        check("t2_jk2", {j, k}, 2'b00);
        check("t2_q1", q_exp, 1'b1);
        drive(1'b0, 2'b00, 4'd0);
        tick();
        check("t2_jk3", {j, k}, 2'b11);
        check("t2_q2", q_exp, 1'b1);
        check("t2_busy_last", busy, 1'b1);
        tick();
        check("t2_jk_idle", {j, k}, 2'b00);
        check("t2_q3", q_exp, 1'b0);
        check("t2_busy_drop", busy, 1'b0);
        check("t2_mismatch", mismatch, 1'b0);

        // SET, then TOGGLE held for 4 cycles
        drive(1'b1, 2'b10, 4'd0);
        tick();
        drive(1'b1, 2'b11, 4'd3);
        tick();
        check("t3_jk_set", {j, k}, 2'b10);
        drive(1'b0, 2'b00, 4'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3_jk_tog%0d", i), {j, k}, 2'b11);
            check($sformatf("t3_q_tog%0d", i), q_exp, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        tick();
        check("t3_jk_idle", {j, k}, 2'b00);
        check("t3_q_final", q_exp, 1'b1);
        check("t3_mismatch", mismatch, 1'b0);

        // Fill the FIFO behind a hold=15 command; stalled entry must not be lost
        drive(1'b1, 2'b00, 4'd15);
        tick();
        drive(1'b1, 2'b10, 4'd0);
        tick();
        check("t4_jk_long", {j, k}, 2'b00);
        check("t4_busy", busy, 1'b1);
        drive(1'b1, 2'b01, 4'd0);
        tick();
        drive(1'b1, 2'b11, 4'd0);
        tick();
        drive(1'b1, 2'b00, 4'd0);
        tick();
        check("t4_full_ready", cmd_ready, 1'b0);
        drive(1'b1, 2'b10, 4'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("t4_stall%0d", i), cmd_ready, 1'b0);
        end
        tick();
        check("t4_e1", {j, k}, 2'b10);
        check("t4_ready_after_pop", cmd_ready, 1'b1);
        tick();
        drive(1'b0, 2'b00, 4'd0);
        check("t4_e2", {j, k}, 2'b01);
        tick();
        check("t4_e3", {j, k}, 2'b11);
        tick();
        check("t4_e4", {j, k}, 2'b00);
        tick();
        check("t4_e5", {j, k}, 2'b10);
        check("t4_busy_e5", busy, 1'b1);
        tick();
        check("t4_jk_idle", {j, k}, 2'b00);
        check("t4_busy_done", busy, 1'b0);
        check("t4_q_exp", q_exp, 1'b1);
        check("t4_mismatch", mismatch, 1'b0);

        // Injected mismatch, then asynchronous reset mid-RUN
        drive(1'b1, 2'b01, 4'd5);
        tick();
        drive(1'b0, 2'b00, 4'd0);
        tick();
        check("t5_jk", {j, k}, 2'b01);
        tick();
        check("t5_q_exp", q_exp, 1'b0);
        check("t5_mismatch_pre", mismatch, 1'b0);
        force_en  = 1'b1;
        force_val = 1'b1;
        tick();
        check("t5_mismatch_set", mismatch, 1'b1);
        force_en = 1'b0;
        tick();
        check("t5_mismatch_sticky", mismatch, 1'b1);
        check("t5_busy_run", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_j", j, 1'b0);
        check("t5_rst_k", k, 1'b0);
        check("t5_rst_q_exp", q_exp, 1'b0);
        check("t5_rst_exp_valid", exp_valid, 1'b0);
        check("t5_rst_mismatch", mismatch, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_ready", cmd_ready, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_ready_again", cmd_ready, 1'b1);
        check("t5_busy_discarded", busy, 1'b0);

        // TOGGLE first after reset: state stays unknown, no mismatch possible
        drive(1'b1, 2'b11, 4'd2);
        force_en = 1'b1;
        tick();
        drive(1'b0, 2'b00, 4'd0);
        for (int i = 0; i < 5; i++) begin
            force_val = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            check($sformatf("t6_jk%0d", i), {j, k}, (i < 3) ? 2'b11 : 2'b00);
            check($sformatf("t6_exp_valid%0d", i), exp_valid, 1'b0);
            check($sformatf("t6_mismatch%0d", i), mismatch, 1'b0);
        end
        force_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
